id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the pipelined RV32I core, directly upstream of the ALU. Captures decoded operands and control from ID, resolves data hazards by forwarding from MEM and WB, and drives the ALU operand and opcode inputs combinationally from its registered state. Detects load-use hazards and inserts one bubble. Carries destination and memory control forward to EX/MEM.

## Interface
- No parameters; XLEN fixed at 32, register address width fixed at 5.
- i_clk  in  1  core clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_stall  in  1  downstream stall; hold all ID/EX state
- i_flush  in  1  branch/jump redirect; load bubble
- i_id_valid  in  1  ID slot holds a real instruction
- i_id_pc, i_id_rs1_data, i_id_rs2_data, i_id_imm  in  32 each  decoded values
- i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr  in  5 each  register indices
- i_id_rs1_used, i_id_rs2_used  in  1 each  instruction reads rs1/rs2
- i_id_alu_op  in  4  ALU opcode in ALU encoding (ADD=0000 … AUIPC=1011)
- i_id_opa_sel  in  2  00 rs1, 01 pc, 10 zero, 11 zero
- i_id_opb_sel  in  1  0 rs2, 1 imm
- i_id_rd_wren, i_id_mem_rden, i_id_mem_wren  in  1 each  writeback/load/store
- i_mem_rd_addr  in  5; i_mem_rd_wren  in  1; i_mem_fwd_data  in  32  MEM-stage ALU result
- i_wb_rd_addr  in  5; i_wb_rd_wren  in  1; i_wb_data  in  32  WB write port
- o_op_a, o_op_b  out  32  ALU operands
- o_alu_op  out  4  ALU opcode
- o_ex_store_data  out  32  forwarded rs2 for stores
- o_ex_pc  out  32; o_ex_rd_addr  out  5; o_ex_rd_wren, o_ex_mem_rden, o_ex_mem_wren, o_ex_valid  out  1 each
- o_load_use  out  1  ID must stall this cycle

## Operation
- State: ex_valid, pc, rs1_val, rs2_val, imm, rs1/rs2/rd addr, alu_op, opa_sel, opb_sel, rd_wren, mem_rden, mem_wren.
- Bubble: valid=0, rd_wren=mem_rden=mem_wren=0, alu_op=0000, all data/addr fields 0.
- Update priority per edge: i_reset → bubble; else i_flush → bubble; else i_stall → hold; else o_load_use → bubble; else capture ID fields (valid = i_id_valid).
- o_load_use = ex_valid & ex_mem_rden & ex_rd_addr≠0 & ((i_id_rs1_used & rs1_addr==ex_rd) | (i_id_rs2_used & rs2_addr==ex_rd)) & ~i_flush.
- Capture-time WB bypass: if i_wb_rd_wren, i_wb_rd_addr≠0 and equals i_id_rsN_addr, capture i_wb_data instead of i_id_rsN_data.
- Hold-time refresh: while held by i_stall, if WB writes a nonzero rd equal to stored rsN addr, rsN_val ← i_wb_data.
- EX forwarding (combinational), per rsN: MEM match (i_mem_rd_wren, addr≠0, addr==ex_rsN) → i_mem_fwd_data; else WB match → i_wb_data; else rsN_val. MEM wins over WB. x0 never forwarded.
- o_op_a per opa_sel from forwarded rs1 / pc / 0; o_op_b per opb_sel from forwarded rs2 / imm. o_ex_store_data = forwarded rs2.
- Bubble outputs: o_op_a=o_op_b=0, o_alu_op=0000.

## Timing
- Reset: all outputs 0 one edge after i_reset high; o_load_use 0.
- Latency: ID fields appear on ALU inputs one cycle after capture edge; forwarding adds no latency.
- Load followed by dependent instruction: exactly one bubble; dependent instruction enters on the next edge and takes load data via WB forwarding (or MEM data on the later edge).
- i_flush and i_stall together: flush wins. i_flush during load-use: bubble, o_load_use 0.
- i_reset mid-stall or mid-load-use: bubble next edge; no capture.
- o_load_use and all forwarding paths are combinational from registered state and same-cycle MEM/WB inputs.

## Test plan
- Reset: hold i_reset 2 cycles with random ID inputs → all outputs 0, o_ex_valid 0.
- Forward priority: EX add rs1=x5; MEM rd=x5 data 0x11, WB rd=x5 data 0x22 → o_op_a=0x11; remove MEM match → 0x22; rd=x0 on both → stored rs1_val.
- Load-use: EX lw rd=x7, ID add rs2=x7 → o_load_use=1, next edge bubble (o_ex_valid 0), following edge add captured, o_op_b=WB 0xDEADBEEF.
- Flush vs stall: i_flush=i_stall=1 with valid EX → next edge bubble; i_stall alone → all outputs held 3 cycles.
- Hold refresh: stalled with rs2=x3, WB writes x3=0x1234 → after stall releases, o_ex_store_data=0x1234 with no MEM/WB match.
- Operand select: AUIPC pc=0x100, imm=0x2000, opa_sel=01, opb_sel=1 → o_op_a=0x100, o_op_b=0x2000, o_alu_op=1011.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with MEM/WB forwarding and load-use bubble insertion
// Ports:
//   i_clk, i_reset             clock, synchronous active-high reset
//   i_stall, i_flush           hold all state / replace with bubble (flush wins)
//   i_id_*                     decoded instruction fields from ID
//   i_mem_*                    MEM-stage destination and ALU result for forwarding
//   i_wb_*                     WB write port, used for forwarding and register bypass
//   o_op_a, o_op_b, o_alu_op   ALU inputs, zero while EX holds a bubble
//   o_ex_*                     destination, memory control and store data carried to EX/MEM
//   o_load_use                 ID must stall: EX load feeds a register ID reads
module id_ex_stage (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_id_valid,
    input  logic [31:0] i_id_pc,
    input  logic [31:0] i_id_rs1_data,
    input  logic [31:0] i_id_rs2_data,
    input  logic [31:0] i_id_imm,
    input  logic [4:0]  i_id_rs1_addr,
    input  logic [4:0]  i_id_rs2_addr,
    input  logic [4:0]  i_id_rd_addr,
    input  logic        i_id_rs1_used,
    input  logic        i_id_rs2_used,
    input  logic [3:0]  i_id_alu_op,
    input  logic [1:0]  i_id_opa_sel,
    input  logic        i_id_opb_sel,
    input  logic        i_id_rd_wren,
    input  logic        i_id_mem_rden,
    input  logic        i_id_mem_wren,
    input  logic [4:0]  i_mem_rd_addr,
    input  logic        i_mem_rd_wren,
    input  logic [31:0] i_mem_fwd_data,
    input  logic [4:0]  i_wb_rd_addr,
    input  logic        i_wb_rd_wren,
    input  logic [31:0] i_wb_data,
    output logic [31:0] o_op_a,
    output logic [31:0] o_op_b,
    output logic [3:0]  o_alu_op,
    output logic [31:0] o_ex_store_data,
    output logic [31:0] o_ex_pc,
    output logic [4:0]  o_ex_rd_addr,
    output logic        o_ex_rd_wren,
    output logic        o_ex_mem_rden,
    output logic        o_ex_mem_wren,
    output logic        o_ex_valid,
    output logic        o_load_use
);
    logic        ex_valid, ex_opb_sel, ex_rd_wren, ex_mem_rden, ex_mem_wren;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic [3:0]  ex_alu_op;
    logic [1:0]  ex_opa_sel;
    logic        wb_en, mem_en;
    logic [31:0] fwd_rs1, fwd_rs2;

    assign wb_en  = i_wb_rd_wren && i_wb_rd_addr != 5'd0;
    assign mem_en = i_mem_rd_wren && i_mem_rd_addr != 5'd0;

    assign o_load_use = ex_valid && ex_mem_rden && ex_rd_addr != 5'd0 && !i_flush &&
                        ((i_id_rs1_used && i_id_rs1_addr == ex_rd_addr) ||
                         (i_id_rs2_used && i_id_rs2_addr == ex_rd_addr));

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush || (!i_stall && o_load_use)) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_val  <= '0;
            ex_rs2_val  <= '0;
            ex_imm      <= '0;
            ex_rs1_addr <= '0;
            ex_rs2_addr <= '0;
            ex_rd_addr  <= '0;
            ex_alu_op   <= '0;
            ex_opa_sel  <= '0;
            ex_opb_sel  <= 1'b0;
            ex_rd_wren  <= 1'b0;
            ex_mem_rden <= 1'b0;
            ex_mem_wren <= 1'b0;
        end else if (i_stall) begin
            // a held instruction must not lose a value that retires while it waits
            if (wb_en && i_wb_rd_addr == ex_rs1_addr) ex_rs1_val <= i_wb_data;
            if (wb_en && i_wb_rd_addr == ex_rs2_addr) ex_rs2_val <= i_wb_data;
        end else begin
            ex_valid    <= i_id_valid;
            ex_pc       <= i_id_pc;
            ex_rs1_val  <= (wb_en && i_wb_rd_addr == i_id_rs1_addr) ? i_wb_data : i_id_rs1_data;
            ex_rs2_val  <= (wb_en && i_wb_rd_addr == i_id_rs2_addr) ? i_wb_data : i_id_rs2_data;
            ex_imm      <= i_id_imm;
            ex_rs1_addr <= i_id_rs1_addr;
            ex_rs2_addr <= i_id_rs2_addr;
            ex_rd_addr  <= i_id_rd_addr;
            ex_alu_op   <= i_id_alu_op;
            ex_opa_sel  <= i_id_opa_sel;
            ex_opb_sel  <= i_id_opb_sel;
            ex_rd_wren  <= i_id_rd_wren;
            ex_mem_rden <= i_id_mem_rden;
            ex_mem_wren <= i_id_mem_wren;
        end
    end

    always_comb begin
        fwd_rs1 = (mem_en && i_mem_rd_addr == ex_rs1_addr) ? i_mem_fwd_data :
                  (wb_en && i_wb_rd_addr == ex_rs1_addr) ? i_wb_data : ex_rs1_val;
        fwd_rs2 = (mem_en && i_mem_rd_addr == ex_rs2_addr) ? i_mem_fwd_data :
                  (wb_en && i_wb_rd_addr == ex_rs2_addr) ? i_wb_data : ex_rs2_val;
        o_op_a  = !ex_valid ? 32'd0 : ex_opa_sel == 2'b00 ? fwd_rs1 : ex_opa_sel == 2'b01 ? ex_pc : 32'd0;
        o_op_b  = !ex_valid ? 32'd0 : ex_opb_sel ? ex_imm : fwd_rs2;
        o_alu_op = ex_valid ? ex_alu_op : 4'd0;
    end

    assign o_ex_store_data = fwd_rs2;
    assign o_ex_pc         = ex_pc;
    assign o_ex_rd_addr    = ex_rd_addr;
    assign o_ex_rd_wren    = ex_rd_wren;
    assign o_ex_mem_rden   = ex_mem_rden;
    assign o_ex_mem_wren   = ex_mem_wren;
    assign o_ex_valid      = ex_valid;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against an instruction-level model
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        id_rs1_used, id_rs2_used;
    logic [3:0]  id_alu_op;
    logic [1:0]  id_opa_sel;
    logic        id_opb_sel, id_rd_wren, id_mem_rden, id_mem_wren;
    logic [4:0]  mem_rd_addr, wb_rd_addr;
    logic        mem_rd_wren, wb_rd_wren;
    logic [31:0] mem_fwd_data, wb_data;
    logic [31:0] op_a, op_b, store_data, ex_pc;
    logic [3:0]  alu_op;
    logic [4:0]  ex_rd_addr;
    logic        ex_rd_wren, ex_mem_rden, ex_mem_wren, ex_valid, load_use;

    int tests = 0;
    int failed = 0;
    bit armed = 0;

    typedef struct packed {
        logic        v;
        logic [31:0] pc, r1, r2, imm;
        logic [4:0]  a1, a2, rd;
        logic [3:0]  op;
        logic [1:0]  as;
        logic        bs, rdw, mrd, mwr;
    } instr_t;

    instr_t m;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_flush(flush),
        .i_id_valid(id_valid), .i_id_pc(id_pc), .i_id_rs1_data(id_rs1_data),
        .i_id_rs2_data(id_rs2_data), .i_id_imm(id_imm), .i_id_rs1_addr(id_rs1_addr),
        .i_id_rs2_addr(id_rs2_addr), .i_id_rd_addr(id_rd_addr), .i_id_rs1_used(id_rs1_used),
        .i_id_rs2_used(id_rs2_used), .i_id_alu_op(id_alu_op), .i_id_opa_sel(id_opa_sel),
        .i_id_opb_sel(id_opb_sel), .i_id_rd_wren(id_rd_wren), .i_id_mem_rden(id_mem_rden),
        .i_id_mem_wren(id_mem_wren), .i_mem_rd_addr(mem_rd_addr), .i_mem_rd_wren(mem_rd_wren),
        .i_mem_fwd_data(mem_fwd_data), .i_wb_rd_addr(wb_rd_addr), .i_wb_rd_wren(wb_rd_wren),
        .i_wb_data(wb_data), .o_op_a(op_a), .o_op_b(op_b), .o_alu_op(alu_op),
        .o_ex_store_data(store_data), .o_ex_pc(ex_pc), .o_ex_rd_addr(ex_rd_addr),
        .o_ex_rd_wren(ex_rd_wren), .o_ex_mem_rden(ex_mem_rden), .o_ex_mem_wren(ex_mem_wren),
        .o_ex_valid(ex_valid), .o_load_use(load_use)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // value a register read in EX sees: youngest producer wins, x0 is constant
    function automatic logic [31:0] reg_value(input logic [4:0] a, input logic [31:0] stored);
        if (a == 0) return stored;
        if (mem_rd_wren && mem_rd_addr == a) return mem_fwd_data;
        if (wb_rd_wren && wb_rd_addr == a) return wb_data;
        return stored;
    endfunction

    function automatic logic exp_load_use();
        if (flush || !m.v || !m.mrd || m.rd == 0) return 1'b0;
        return (id_rs1_used && id_rs1_addr == m.rd) || (id_rs2_used && id_rs2_addr == m.rd);
    endfunction

    function automatic logic [31:0] wb_or(input logic [4:0] a, input logic [31:0] d);
        return (wb_rd_wren && a != 0 && wb_rd_addr == a) ? wb_data : d;
    endfunction

    function automatic instr_t next_instr();
        instr_t n;
        if (reset || flush) return '0;
        if (stall) begin
            n = m;
            n.r1 = wb_or(m.a1, m.r1);
            n.r2 = wb_or(m.a2, m.r2);
            return n;
        end
        if (exp_load_use()) return '0;
        n.v = id_valid; n.pc = id_pc; n.imm = id_imm;
        n.r1 = wb_or(id_rs1_addr, id_rs1_data);
        n.r2 = wb_or(id_rs2_addr, id_rs2_data);
        n.a1 = id_rs1_addr; n.a2 = id_rs2_addr; n.rd = id_rd_addr;
        n.op = id_alu_op; n.as = id_opa_sel; n.bs = id_opb_sel;
        n.rdw = id_rd_wren; n.mrd = id_mem_rden; n.mwr = id_mem_wren;
        return n;
    endfunction

    task automatic compare_model();
        logic [31:0] a, b;
        a = !m.v ? 32'd0 : m.as == 2'd0 ? reg_value(m.a1, m.r1) : m.as == 2'd1 ? m.pc : 32'd0;
        b = !m.v ? 32'd0 : m.bs ? m.imm : reg_value(m.a2, m.r2);
        check("op_a", op_a, a);
        check("op_b", op_b, b);
        check("alu_op", {28'd0, alu_op}, m.v ? {28'd0, m.op} : 32'd0);
        check("store_data", store_data, reg_value(m.a2, m.r2));
        check("ex_pc", ex_pc, m.pc);
        check("rd_addr", {27'd0, ex_rd_addr}, {27'd0, m.rd});
        check("ctrl", {28'd0, ex_valid, ex_rd_wren, ex_mem_rden, ex_mem_wren}, {28'd0, m.v, m.rdw, m.mrd, m.mwr});
        check("load_use", {31'd0, load_use}, {31'd0, exp_load_use()});
    endtask

    task automatic step();
        instr_t n;
        #1;
        if (armed) compare_model();
        n = next_instr();
        @(posedge clk);
        m = n;
        @(negedge clk);
    endtask

    task automatic clear();
        {reset, stall, flush, id_valid, id_rs1_used, id_rs2_used} = '0;
        {id_pc, id_rs1_data, id_rs2_data, id_imm} = '0;
        {id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_op, id_opa_sel} = '0;
        {id_opb_sel, id_rd_wren, id_mem_rden, id_mem_wren} = '0;
        {mem_rd_addr, mem_rd_wren, mem_fwd_data, wb_rd_addr, wb_rd_wren, wb_data} = '0;
    endtask

    task automatic rand_id();
        id_valid = $urandom_range(0, 3) != 0;
        id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
        id_rs1_addr = 5'($urandom_range(0, 3)); id_rs2_addr = 5'($urandom_range(0, 3));
        id_rd_addr = 5'($urandom_range(0, 3));
        id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom);
        id_alu_op = 4'($urandom); id_opa_sel = 2'($urandom); id_opb_sel = 1'($urandom);
        id_rd_wren = 1'($urandom); id_mem_rden = 1'($urandom); id_mem_wren = 1'($urandom);
    endtask

    task automatic rand_fwd();
        mem_rd_addr = 5'($urandom_range(0, 3)); mem_rd_wren = 1'($urandom); mem_fwd_data = $urandom;
        wb_rd_addr = 5'($urandom_range(0, 3)); wb_rd_wren = 1'($urandom); wb_data = $urandom;
    endtask

    task automatic load_instr(input logic [4:0] rd);
        clear();
        id_valid = 1; id_rs1_addr = 2; id_rs1_used = 1; id_rs1_data = 32'h1000;
        id_imm = 4; id_opb_sel = 1; id_rd_addr = rd; id_rd_wren = 1; id_mem_rden = 1;
    endtask

    initial begin
        clear();
        rand_id();
        rand_fwd();
        reset = 1;
        m = '0;
        @(negedge clk);
        step();
        armed = 1;
        step();
        #1;
        check("rst_op_a", op_a, 0);
        check("rst_op_b", op_b, 0);
        check("rst_store", store_data, 0);
        check("rst_ctrl", {ex_valid, ex_rd_wren, ex_mem_rden, ex_mem_wren, alu_op, ex_rd_addr}, 0);

        clear();
        id_valid = 1; id_rs1_addr = 5; id_rs1_used = 1; id_rs1_data = 32'hAA;
        id_rs2_addr = 6; id_rs2_used = 1; id_rs2_data = 32'h33; id_rd_addr = 8; id_rd_wren = 1;
        step();
        clear();
        mem_rd_addr = 5; mem_rd_wren = 1; mem_fwd_data = 32'h11;
        wb_rd_addr = 5; wb_rd_wren = 1; wb_data = 32'h22;
        #1 check("fwd_mem_wins", op_a, 32'h11);
        mem_rd_wren = 0;
        #1 check("fwd_wb", op_a, 32'h22);
        mem_rd_wren = 1; mem_rd_addr = 0; wb_rd_addr = 0;
        #1 check("fwd_x0", op_a, 32'hAA);
        step();

        load_instr(7);
        step();
        clear();
        id_valid = 1; id_rs1_addr = 1; id_rs1_used = 1; id_rs2_addr = 7; id_rs2_used = 1;
        id_rs2_data = 32'h99; id_rd_addr = 9; id_rd_wren = 1;
        #1 check("lu_set", load_use, 1);
        step();
        #1 check("lu_bubble", ex_valid, 0);
        check("lu_clear", load_use, 0);
        step();
        wb_rd_addr = 7; wb_rd_wren = 1; wb_data = 32'hDEADBEEF;
        #1 check("lu_add_valid", ex_valid, 1);
        check("lu_wb_fwd", op_b, 32'hDEADBEEF);
        step();

        clear();
        id_valid = 1; id_pc = 32'h40; id_rs1_addr = 1; id_rs1_data = 32'h10; id_rs2_addr = 2;
        id_rs2_data = 32'h20; id_imm = 32'h30; id_alu_op = 3; id_rd_addr = 4; id_rd_wren = 1;
        step();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            rand_id();
            #1;
            check("hold_op_a", op_a, 32'h10);
            check("hold_op_b", op_b, 32'h20);
            check("hold_misc", {ex_pc[7:0], alu_op, ex_rd_addr, ex_valid}, {8'h40, 4'd3, 5'd4, 1'b1});
            step();
        end
        flush = 1;
        step();
        #1 check("flush_over_stall", {ex_valid, op_a}, 0);

        clear();
        id_valid = 1; id_rs1_addr = 1; id_rs1_data = 32'h100; id_rs2_addr = 3; id_rs2_used = 1;
        id_rs2_data = 32'h55; id_imm = 8; id_opb_sel = 1; id_mem_wren = 1;
        step();
        clear();
        stall = 1; wb_rd_addr = 3; wb_rd_wren = 1; wb_data = 32'h1234;
        step();
        wb_rd_wren = 0;
        #1 check("hold_refresh", store_data, 32'h1234);
        stall = 0;
        step();

        clear();
        id_valid = 1; id_pc = 32'h100; id_imm = 32'h2000; id_opa_sel = 2'b01; id_opb_sel = 1;
        id_alu_op = 4'b1011; id_rd_addr = 5; id_rd_wren = 1;
        step();
        clear();
        #1 check("auipc_a", op_a, 32'h100);
        check("auipc_b", op_b, 32'h2000);
        check("auipc_op", alu_op, 4'b1011);
        step();

        load_instr(7);
        step();
        clear();
        id_valid = 1; id_rs1_addr = 7; id_rs1_used = 1; flush = 1;
        #1 check("flush_lu", load_use, 0);
        step();
        #1 check("flush_lu_bubble", ex_valid, 0);

        load_instr(6);
        step();
        clear();
        stall = 1; reset = 1; rand_id();
        step();
        #1 check("reset_mid_stall", {ex_valid, ex_mem_rden, ex_rd_addr}, 0);

        for (int i = 0; i < 400; i++) begin
            rand_id();
            rand_fwd();
            reset = $urandom_range(0, 39) == 0;
            flush = $urandom_range(0, 9) == 0;
            stall = $urandom_range(0, 4) == 0;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
